dm_wb_cache: RTL and testbench

Parametrised direct-mapped write-back, write-allocate cache controller sitting between a single CPU-side requester and a word-wide main-memory port. It generalises the fixed 17-bit / 1024-line / 16-word cache to configurable geometry. It adds:
- a valid/ready request handshake with an explicit response pulse;
- multi-cycle burst refill and writeback that tolerate memory backpressure;
- correct miss completion, so a dirty miss performs writeback, refill and the access in one transaction;
- a whole-cache flush command.

---
 rtl/dm_wb_cache.sv | 188 ++++++++++++++++++
 tb/tb_dm_wb_cache.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache between one CPU requester and a
// word-wide memory port, with burst refill/writeback and a whole-cache flush.
module dm_wb_cache #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int NUM_LINES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state_o
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESP, S_FLUSH_SCAN, S_FLUSH_WB
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   data_q [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]    tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [OFF_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    fidx_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx, cur_idx;
    logic [OFF_W-1:0] req_off;
    logic             in_flush, line_hit, xfer, last_word, flush_line_dirty;

    assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx   = addr_q[OFF_W +: IDX_W];
    assign req_off   = addr_q[OFF_W-1:0];
    assign in_flush  = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
    // Writeback bursts use the same datapath for victim eviction and flush.
    assign cur_idx   = in_flush ? fidx_q : req_idx;
    assign line_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign xfer      = mem_valid && mem_ready;
    assign last_word = &cnt_q;
    assign flush_line_dirty = valid_q[fidx_q] && dirty_q[fidx_q];

    // Memory port: valid/addr/we/wdata derive only from registers that change on a
    // transfer, so they stay stable while mem_ready is low; a word moves when
    // mem_valid && mem_ready are both high at a rising edge.
    assign mem_valid  = (state_q == S_WRITEBACK) || (state_q == S_REFILL) ||
                        (state_q == S_FLUSH_WB);
    assign mem_we     = (state_q == S_WRITEBACK) || (state_q == S_FLUSH_WB);
    assign mem_addr   = {(state_q == S_REFILL) ? req_tag : tag_q[cur_idx], cur_idx, cnt_q};
    assign mem_wdata  = data_q[{cur_idx, cnt_q}];
    assign req_ready  = (state_q == S_IDLE) && !flush_req;
    assign flush_done = ((state_q == S_FLUSH_SCAN) && (&fidx_q) && !flush_line_dirty) ||
                        ((state_q == S_FLUSH_WB) && xfer && last_word && (&fidx_q));
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign dbg_state_o = state_q;

    logic                   data_we;
    logic [IDX_W+OFF_W-1:0] data_wa;
    logic [DATA_W-1:0]      data_wd;

    always_comb begin
        data_we = 1'b0;
        data_wa = '0;
        data_wd = '0;
        if (state_q == S_REFILL && xfer) begin
            data_we = 1'b1;
            data_wa = {req_idx, cnt_q};
            data_wd = mem_rdata;
        end else if (state_q == S_RESP && we_q) begin
            data_we = 1'b1;
            data_wa = {req_idx, req_off};
            data_wd = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[data_wa] <= data_wd;
        if (state_q == S_REFILL && xfer && last_word) tag_q[req_idx] <= req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            fidx_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_req) begin
                        fidx_q  <= '0;
                        state_q <= S_FLUSH_SCAN;
                    end else if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    cnt_q <= '0;
                    if (line_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? wdata_q : data_q[{req_idx, req_off}];
                        state_q      <= S_RESP;
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_q <= S_WRITEBACK;
                    end else begin
                        state_q <= S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            dirty_q[req_idx] <= 1'b0;
                            state_q          <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            valid_q[req_idx] <= 1'b1;
                            resp_valid_q     <= 1'b1;
                            // The requested word may be arriving on this very transfer.
                            resp_rdata_q <= we_q ? wdata_q :
                                            (cnt_q == req_off) ? mem_rdata :
                                            data_q[{req_idx, req_off}];
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (we_q) dirty_q[req_idx] <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_FLUSH_SCAN: begin
                    cnt_q <= '0;
                    if (flush_line_dirty) state_q <= S_FLUSH_WB;
                    else if (&fidx_q)     state_q <= S_IDLE;
                    else                  fidx_q  <= fidx_q + 1'b1;
                end
                S_FLUSH_WB: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            dirty_q[fidx_q] <= 1'b0;
                            fidx_q          <= fidx_q + 1'b1;
                            state_q         <= (&fidx_q) ? S_IDLE : S_FLUSH_SCAN;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_wb_cache.sv
// Bench for dm_wb_cache: memory responder with backpressure, transparent-memory
// reference model of the cache, and one task per scenario.
module tb_dm_wb_cache;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int NL     = 1024;

    logic              clk = 1'b0;
    logic              rst, req_valid, req_ready, req_we, resp_valid;
    logic              flush_req, flush_done, mem_valid, mem_ready, mem_we;
    logic [ADDR_W-1:0] req_addr, mem_addr;
    logic [DATA_W-1:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
    logic [2:0]        dbg_state;

    int checks = 0;
    int passes = 0;

    dm_wb_cache dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory: unwritten words read back as their own address.
    logic [DATA_W-1:0] mem_img [logic [ADDR_W-1:0]];
    int   ready_mode = 0;
    logic alt = 1'b1;

    always @(negedge clk) begin
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 3) != 0);
            default: begin mem_ready = alt; alt = ~alt; end
        endcase
        mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : DATA_W'(mem_addr);
    end

    logic [31:0] wb_addr_log[$], wb_data_log[$], rf_addr_log[$];
    int   stall_cnt, stall_viol;
    logic stalled = 1'b0;
    logic [ADDR_W-1:0] st_addr;
    logic st_we;
    logic [DATA_W-1:0] st_wdata;

    always @(posedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && (!mem_valid || mem_addr !== st_addr || mem_we !== st_we ||
                            (st_we && mem_wdata !== st_wdata)))
                stall_viol++;
            stalled = 1'b0;
            if (mem_valid) begin
                if (mem_ready) begin
                    if (mem_we) begin
                        wb_addr_log.push_back(32'(mem_addr));
                        wb_data_log.push_back(mem_wdata);
                        mem_img[mem_addr] = mem_wdata;
                    end else begin
                        rf_addr_log.push_back(32'(mem_addr));
                    end
                end else begin
                    stall_cnt++;
                    stalled  = 1'b1;
                    st_addr  = mem_addr;
                    st_we    = mem_we;
                    st_wdata = mem_wdata;
                end
            end
        end
    end

    // Reference model: the cache is transparent, so every address reads its latest
    // written value; line bookkeeping only predicts the memory traffic.
    logic              ref_valid [NL];
    logic              ref_dirty [NL];
    logic [2:0]        ref_tag   [NL];
    logic [DATA_W-1:0] arch [logic [ADDR_W-1:0]];
    logic [31:0]       exp_wb_a[$], exp_wb_d[$], exp_rf_a[$];
    logic [DATA_W-1:0] exp_q[$];

    function automatic logic [DATA_W-1:0] arch_rd(input logic [ADDR_W-1:0] a);
        return arch.exists(a) ? arch[a] : DATA_W'(a);
    endfunction

    function automatic int qdiff(input logic [31:0] a[$], input logic [31:0] b[$]);
        int n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        int m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; end
        arch.delete();
        foreach (mem_img[a]) arch[a] = mem_img[a];
    endtask

    task automatic model_access(input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] wd, output int xfers);
        int idx = int'(a[13:4]);
        logic [ADDR_W-1:0] la;
        xfers = 0;
        if (!(ref_valid[idx] && ref_tag[idx] == a[16:14])) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                for (int k = 0; k < 16; k++) begin
                    la = {ref_tag[idx], a[13:4], 4'(k)};
                    exp_wb_a.push_back(32'(la));
                    exp_wb_d.push_back(arch_rd(la));
                    xfers++;
                end
            end
            for (int k = 0; k < 16; k++) begin
                exp_rf_a.push_back(32'({a[16:4], 4'(k)}));
                xfers++;
            end
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[16:14];
            ref_dirty[idx] = 1'b0;
        end
        if (we) begin
            arch[a] = wd;
            ref_dirty[idx] = 1'b1;
        end
        exp_q.push_back(arch_rd(a));
    endtask

    task automatic model_flush(output int xfers);
        xfers = 0;
        for (int i = 0; i < NL; i++) begin
            if (ref_valid[i] && ref_dirty[i]) begin
                for (int k = 0; k < 16; k++) begin
                    exp_wb_a.push_back(32'({ref_tag[i], 10'(i), 4'(k)}));
                    exp_wb_d.push_back(arch_rd({ref_tag[i], 10'(i), 4'(k)}));
                    xfers++;
                end
                ref_dirty[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        wb_addr_log.delete(); wb_data_log.delete(); rf_addr_log.delete();
        exp_wb_a.delete(); exp_wb_d.delete(); exp_rf_a.delete(); exp_q.delete();
        stall_cnt = 0; stall_viol = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Driver: waits for req_ready, presents one request for the accept edge, then
    // counts cycles (acceptance = cycle 0) until resp_valid, sampling on negedges.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd,
                          output logic [DATA_W-1:0] rd, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 2000) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        rd  = 'x;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (resp_valid) begin lat = c; rd = resp_rdata; break; end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else passes++;
        checks++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done got=%b exp=0", flush_done); else passes++;
        checks++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); else passes++;
        checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); else passes++;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else passes++;
        flush_req = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL ready_under_flush got=%b exp=0", req_ready); else passes++;
        flush_req = 1'b0;
    endtask

    task automatic test_clean_miss();
        logic [DATA_W-1:0] rd;
        int lat, x;
        clear_logs();
        model_access(1'b0, 17'h00005, '0, x);
        do_req(1'b0, 17'h00005, '0, rd, lat);
        checks++; if (rd !== exp_q[0]) $display("FAIL clean_miss_data got=%h exp=%h", rd, exp_q[0]); else passes++;
        checks++; if (lat !== 18) $display("FAIL clean_miss_latency got=%0d exp=18", lat); else passes++;
        checks++; if (qdiff(rf_addr_log, exp_rf_a) != 0 || wb_addr_log.size() != 0)
            $display("FAIL clean_miss_traffic got_rf=%0d got_wb=%0d exp_rf=%0d exp_wb=0", rf_addr_log.size(), wb_addr_log.size(), exp_rf_a.size());
        else passes++;
        clear_logs();
        model_access(1'b0, 17'h00006, '0, x);
        do_req(1'b0, 17'h00006, '0, rd, lat);
        checks++; if (rd !== 32'h6) $display("FAIL hit_data got=%h exp=00000006", rd); else passes++;
        checks++; if (lat !== 2) $display("FAIL hit_latency got=%0d exp=2", lat); else passes++;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL hit_cycle3 got_ready=%b got_resp=%b exp_ready=1 exp_resp=0", req_ready, resp_valid);
        else passes++;
    endtask

    task automatic test_dirty_miss();
        logic [DATA_W-1:0] rd, w6;
        int lat, x;
        clear_logs();
        model_access(1'b1, 17'h00006, 32'hDEADBEEF, x);
        do_req(1'b1, 17'h00006, 32'hDEADBEEF, rd, lat);
        checks++; if (rd !== 32'hDEADBEEF || lat !== 2)
            $display("FAIL write_hit got=%h/%0d exp=deadbeef/2", rd, lat);
        else passes++;
        clear_logs();
        model_access(1'b0, 17'h04006, '0, x);
        do_req(1'b0, 17'h04006, '0, rd, lat);
        checks++; if (rd !== 32'h4006) $display("FAIL dirty_miss_data got=%h exp=00004006", rd); else passes++;
        checks++; if (lat !== 34) $display("FAIL dirty_miss_latency got=%0d exp=34", lat); else passes++;
        checks++; if (qdiff(wb_addr_log, exp_wb_a) != 0 || qdiff(wb_data_log, exp_wb_d) != 0)
            $display("FAIL dirty_miss_writeback got_n=%0d exp_n=%0d", wb_addr_log.size(), exp_wb_a.size());
        else passes++;
        w6 = (wb_data_log.size() == 16) ? wb_data_log[6] : 'x;
        checks++; if (w6 !== 32'hDEADBEEF) $display("FAIL dirty_miss_word6 got=%h exp=deadbeef", w6); else passes++;
        checks++; if (qdiff(rf_addr_log, exp_rf_a) != 0)
            $display("FAIL dirty_miss_refill got_n=%0d exp_n=%0d", rf_addr_log.size(), exp_rf_a.size());
        else passes++;
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] rd;
        int lat, x;
        clear_logs();
        ready_mode = 2;
        model_access(1'b0, 17'h08345, '0, x);
        do_req(1'b0, 17'h08345, '0, rd, lat);
        ready_mode = 0;
        checks++; if (rd !== exp_q[0]) $display("FAIL stall_data got=%h exp=%h", rd, exp_q[0]); else passes++;
        checks++; if (stall_cnt < 1 || lat !== 18 + stall_cnt)
            $display("FAIL stall_latency got=%0d exp=%0d stalls=%0d", lat, 18 + stall_cnt, stall_cnt);
        else passes++;
        checks++; if (stall_viol !== 0) $display("FAIL stall_stability got=%0d exp=0", stall_viol); else passes++;
        checks++; if (qdiff(rf_addr_log, exp_rf_a) != 0)
            $display("FAIL stall_refill got_n=%0d exp_n=%0d", rf_addr_log.size(), exp_rf_a.size());
        else passes++;
    endtask

    task automatic run_flush(output int done_at, output int pulses, output logic rdy1);
        int cyc = 0;
        done_at = -1; pulses = 0; rdy1 = 1'bx;
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk);
        #1 flush_req = 1'b0;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) rdy1 = req_ready;
            if (flush_done) begin pulses++; if (done_at < 0) done_at = cyc; end
            if (done_at >= 0 && cyc > done_at + 2) break;
        end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] rd, wa, wb;
        int lat, x, done_at, pulses;
        logic rdy1;
        wa = $urandom; wb = $urandom;
        clear_logs();
        model_access(1'b1, 17'h04001, wa, x);
        do_req(1'b1, 17'h04001, wa, rd, lat);
        model_access(1'b1, 17'h03FF3, wb, x);
        do_req(1'b1, 17'h03FF3, wb, rd, lat);
        clear_logs();
        model_flush(x);
        run_flush(done_at, pulses, rdy1);
        checks++; if (wb_addr_log.size() !== 32) $display("FAIL flush_count got=%0d exp=32", wb_addr_log.size()); else passes++;
        checks++; if (qdiff(wb_addr_log, exp_wb_a) != 0 || qdiff(wb_data_log, exp_wb_d) != 0)
            $display("FAIL flush_writeback got_n=%0d exp_n=%0d", wb_addr_log.size(), exp_wb_a.size());
        else passes++;
        checks++; if (done_at !== NL + 32) $display("FAIL flush_done_cycle got=%0d exp=%0d", done_at, NL + 32); else passes++;
        checks++; if (pulses !== 1) $display("FAIL flush_done_pulses got=%0d exp=1", pulses); else passes++;
        checks++; if (rdy1 !== 1'b0) $display("FAIL flush_busy_ready got=%b exp=0", rdy1); else passes++;
        clear_logs();
        run_flush(done_at, pulses, rdy1);
        checks++; if (done_at !== NL || wb_addr_log.size() !== 0)
            $display("FAIL clean_flush got_cycle=%0d got_wb=%0d exp_cycle=%0d exp_wb=0", done_at, wb_addr_log.size(), NL);
        else passes++;
        clear_logs();
        model_access(1'b0, 17'h04001, '0, x);
        do_req(1'b0, 17'h04001, '0, rd, lat);
        checks++; if (rd !== exp_q[0] || lat !== 2) $display("FAIL flush_reread0 got=%h/%0d exp=%h/2", rd, lat, exp_q[0]); else passes++;
        model_access(1'b0, 17'h03FF3, '0, x);
        do_req(1'b0, 17'h03FF3, '0, rd, lat);
        checks++; if (rd !== exp_q[1] || lat !== 2) $display("FAIL flush_reread1023 got=%h/%0d exp=%h/2", rd, lat, exp_q[1]); else passes++;
    endtask

    task automatic test_write_miss();
        logic [DATA_W-1:0] rd;
        int lat, x;
        clear_logs();
        model_access(1'b1, 17'h00123, 32'hA5A5A5A5, x);
        do_req(1'b1, 17'h00123, 32'hA5A5A5A5, rd, lat);
        checks++; if (rd !== 32'hA5A5A5A5 || lat !== 18)
            $display("FAIL write_miss got=%h/%0d exp=a5a5a5a5/18", rd, lat);
        else passes++;
        checks++; if (qdiff(rf_addr_log, exp_rf_a) != 0)
            $display("FAIL write_miss_refill got_n=%0d exp_n=%0d", rf_addr_log.size(), exp_rf_a.size());
        else passes++;
        model_access(1'b0, 17'h00123, '0, x);
        do_req(1'b0, 17'h00123, '0, rd, lat);
        checks++; if (rd !== 32'hA5A5A5A5 || lat !== 2)
            $display("FAIL write_miss_reread got=%h/%0d exp=a5a5a5a5/2", rd, lat);
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        logic [DATA_W-1:0] rd;
        int lat, x;
        clear_logs();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 17'h0A567; req_wdata = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rf_addr_log.size() == 7) break;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL reset_mid_burst got_mv=%b got_rdy=%b exp_mv=0 exp_rdy=1", mem_valid, req_ready);
        else passes++;
        model_reset();
        clear_logs();
        model_access(1'b0, 17'h0A567, '0, x);
        do_req(1'b0, 17'h0A567, '0, rd, lat);
        checks++; if (rd !== exp_q[0] || lat !== 18)
            $display("FAIL reset_reread got=%h/%0d exp=%h/18", rd, lat, exp_q[0]);
        else passes++;
        checks++; if (qdiff(rf_addr_log, exp_rf_a) != 0)
            $display("FAIL reset_reread_refill got_n=%0d exp_n=%0d", rf_addr_log.size(), exp_rf_a.size());
        else passes++;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] rd, wd;
        logic [ADDR_W-1:0] a;
        logic [9:0] idx;
        logic we;
        int lat, x;
        ready_mode = 1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       idx = 10'd0;
                1:       idx = 10'd1;
                2:       idx = 10'd1023;
                default: idx = 10'($urandom_range(0, 1023));
            endcase
            a  = {3'($urandom_range(0, 3)), idx, 4'($urandom_range(0, 15))};
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            clear_logs();
            model_access(we, a, wd, x);
            do_req(we, a, wd, rd, lat);
            checks++; if (rd !== exp_q[0]) $display("FAIL rand_data n=%0d addr=%h got=%h exp=%h", n, a, rd, exp_q[0]); else passes++;
            checks++; if (lat !== 2 + x + stall_cnt) $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, 2 + x + stall_cnt); else passes++;
            checks++; if (qdiff(wb_addr_log, exp_wb_a) != 0 || qdiff(wb_data_log, exp_wb_d) != 0 ||
                          qdiff(rf_addr_log, exp_rf_a) != 0 || stall_viol != 0)
                $display("FAIL rand_traffic n=%0d got_wb=%0d got_rf=%0d exp_wb=%0d exp_rf=%0d viol=%0d",
                         n, wb_addr_log.size(), rf_addr_log.size(), exp_wb_a.size(), exp_rf_a.size(), stall_viol);
            else passes++;
        end
        ready_mode = 0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        flush_req = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_stall();
        test_flush();
        test_write_miss();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
